add_serial_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one bit-serial adder core among NREQ requesters.
//  It samples the winner's operands, launches the core with a one-cycle start pulse,
//  and waits for the core's done strobe, guarded by a watchdog.
//  It then returns the sum to the winner with a one-cycle response.

---
 rtl/add_serial_arb.sv | 132 +++++++++++++
 tb/tb_add_serial_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial_arb.sv
// Round-robin sequencer sharing one bit-serial adder core among NREQ clients.
// One transaction in flight; a watchdog turns a silent core into an error response.
module add_serial_arb #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  add_start,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic                  add_done,
    input  logic [WIDTH-1:0]      add_sum
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [WW-1:0] wd;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          grab;
    logic          done_ok;
    logic          tmo;

    // First set req bit at or after rr_ptr, wrapping past NREQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grab      = 1'b0;
        done_ok   = 1'b0;
        tmo       = 1'b0;
        add_start = 1'b0;
        busy      = 1'b1;
        rsp_valid = '0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (win_found) begin
                    grab      = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                add_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (add_done) begin
                    done_ok   = 1'b1;
                    state_nxt = S_RESP;
                end else if (wd == WW'(TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = NREQ'(1) << grant;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            grant   <= '0;
            wd      <= '0;
            add_a   <= '0;
            add_b   <= '0;
            rsp_sum <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (grab) begin
                grant <= win_idx;
                add_a <= op_a[win_idx*WIDTH +: WIDTH];
                add_b <= op_b[win_idx*WIDTH +: WIDTH];
            end
            if (state == S_LAUNCH)    wd <= '0;
            else if (state == S_WAIT) wd <= wd + 1'b1;
            if (done_ok) begin
                rsp_sum <= add_sum;
                rsp_err <= 1'b0;
            end else if (tmo) begin
                rsp_sum <= '0;
                rsp_err <= 1'b1;
            end
            // Pointer moves past the served client, error or not.
            if (state == S_RESP)
                rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end

endmodule

// File: tb/tb_add_serial_arb.sv
// Directed bench for add_serial_arb with a behavioural serial-adder core.
// Core answers core_delay cycles after the add_start cycle when enabled.
module tb_add_serial_arb;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_err;
    logic                  busy;
    logic                  add_start;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_done;
    logic [WIDTH-1:0]      add_sum;

    logic            core_done;
    logic            stray;
    logic [WIDTH-1:0] core_res;
    logic            core_en;
    int              core_delay;
    int              core_cnt;
    int              cyc;
    int              launch_cyc;
    int              rsp_cyc;
    logic            seen;
    logic [NREQ-1:0] got_v;
    logic [WIDTH-1:0] got_s;
    logic            got_e;
    int              n_vec;
    int              n_err;

    logic [NREQ-1:0]  exp_v [5];
    logic [WIDTH-1:0] exp_s [5];

    assign add_done = core_done | stray;
    assign add_sum  = core_res;

    always #5 clk = ~clk;

    add_serial_arb #(
        .NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
        .busy(busy), .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_sum(add_sum)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a,
                          input logic [7:0] b);
        op_a[i*WIDTH +: WIDTH] = a;
        op_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done = 1'b1;
                core_res  = add_a + add_b;
            end
        end
        if (add_start) begin
            launch_cyc = cyc;
            if (core_en) core_cnt = core_delay;
        end
        if (rsp_valid != '0) begin
            seen    = 1'b1;
            got_v   = rsp_valid;
            got_s   = rsp_sum;
            got_e   = rsp_err;
            rsp_cyc = cyc;
        end
    endtask

    task automatic wait_rsp(input int maxc);
        seen  = 1'b0;
        got_v = '0;
        got_s = '0;
        got_e = 1'b0;
        rsp_cyc = -1000;
        for (int i = 0; i < maxc && !seen; i++) step();
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b1; req = '0; op_a = '0; op_b = '0;
        stray = 1'b0; core_done = 1'b0; core_res = '0;
        core_en = 1'b1; core_delay = 9; core_cnt = 0;
        launch_cyc = 0; rsp_cyc = 0; seen = 1'b0;
        got_v = '0; got_s = '0; got_e = 1'b0;
        exp_v[0] = 4'b0001; exp_s[0] = 8'h33;
        exp_v[1] = 4'b0010; exp_s[1] = 8'h45;
        exp_v[2] = 4'b0100; exp_s[2] = 8'h80;
        exp_v[3] = 4'b1000; exp_s[3] = 8'h01;
        exp_v[4] = 4'b0001; exp_s[4] = 8'h33;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(add_start), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_add_a", 32'(add_a), 0);
        rst = 1'b0;

        // T1 single request
        set_op(0, 8'h25, 8'h13);
        req = 4'b0001;
        core_delay = 9;
        step();
        chk("t1_start", 32'(add_start), 1);
        chk("t1_add_a", 32'(add_a), 32'h25);
        chk("t1_add_b", 32'(add_b), 32'h13);
        chk("t1_busy", 32'(busy), 1);
        wait_rsp(40);
        chk("t1_valid", 32'(got_v), 32'h1);
        chk("t1_sum", 32'(got_s), 32'h38);
        chk("t1_err", 32'(got_e), 0);
        chk("t1_lat", 32'(rsp_cyc - launch_cyc), 10);
        req = '0;
        step();
        chk("t1_pulse", 32'(rsp_valid), 0);
        chk("t1_idle", 32'(busy), 0);

        // T2/T3 fairness and wrap, starting from a fresh pointer
        #3 rst = 1'b1;
        step();
        rst = 1'b0;
        set_op(0, 8'h11, 8'h22);
        set_op(1, 8'h40, 8'h05);
        set_op(2, 8'h7F, 8'h01);
        set_op(3, 8'hFF, 8'h02);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(40);
            chk($sformatf("t2_valid%0d", i), 32'(got_v), 32'(exp_v[i]));
            chk($sformatf("t2_sum%0d", i), 32'(got_s), 32'(exp_s[i]));
            chk($sformatf("t2_err%0d", i), 32'(got_e), 0);
        end
        req = '0;
        step();

        // T4 watchdog timeout
        core_en = 1'b0;
        req = 4'b0010;
        wait_rsp(40);
        chk("t4_valid", 32'(got_v), 32'h2);
        chk("t4_err", 32'(got_e), 1);
        chk("t4_sum", 32'(got_s), 0);
        chk("t4_lat", 32'(rsp_cyc - launch_cyc), TIMEOUT + 1);
        req = '0;
        core_en = 1'b1;
        step();
        chk("t4_idle", 32'(busy), 0);

        // T5 done on the last watchdog cycle wins
        core_delay = TIMEOUT;
        req = 4'b0100;
        wait_rsp(40);
        chk("t5_valid", 32'(got_v), 32'h4);
        chk("t5_err", 32'(got_e), 0);
        chk("t5_sum", 32'(got_s), 32'h80);
        chk("t5_lat", 32'(rsp_cyc - launch_cyc), TIMEOUT + 1);
        req = '0;

        // stray add_done in IDLE and LAUNCH
        stray = 1'b1;
        seen = 1'b0;
        repeat (4) step();
        chk("t5_stray_idle", 32'(seen), 0);
        chk("t5_stray_busy", 32'(busy), 0);
        core_delay = 5;
        req = 4'b1000;
        step();
        chk("t5_launch", 32'(add_start), 1);
        step();
        stray = 1'b0;
        chk("t5_stray_launch", 32'(seen), 0);
        chk("t5_wait_busy", 32'(busy), 1);
        wait_rsp(40);
        chk("t5_valid3", 32'(got_v), 32'h8);
        chk("t5_sum3", 32'(got_s), 32'h01);
        chk("t5_lat3", 32'(rsp_cyc - launch_cyc), 6);
        req = '0;
        step();

        // T6 reset in WAIT aborts the transaction
        core_en = 1'b0;
        req = 4'b0001;
        repeat (3) step();
        chk("t6_in_wait", 32'(busy), 1);
        #3 rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_start", 32'(add_start), 0);
        chk("t6_valid", 32'(rsp_valid), 0);
        chk("t6_add_a", 32'(add_a), 0);
        chk("t6_sum", 32'(rsp_sum), 0);
        req = '0;
        seen = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("t6_no_rsp", 32'(seen), 0);
        core_en = 1'b1;
        core_cnt = 0;
        core_delay = 3;
        req = 4'b0100;
        wait_rsp(40);
        chk("t6_valid2", 32'(got_v), 32'h4);
        chk("t6_sum2", 32'(got_s), 32'h80);
        chk("t6_err2", 32'(got_e), 0);
        chk("t6_lat2", 32'(rsp_cyc - launch_cyc), 4);
        req = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
